// File: rtl/hex_cal_pkg.sv
// hex_cal_pkg: shared definitions for the hex calculator execution stage.
// This package holds the following:
//   - operator and data_type codes
//   - FSM state constants
//   - ASCII constants
//   - the captured-command struct
//   - the nibble-to-ASCII helper
package hex_cal_pkg;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_DIV = 5'd4;

  localparam logic [3:0] DT_SIGNED   = 4'd2;
  localparam logic [3:0] DT_UNSIGNED = 4'd3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] EMIT = 2'd3;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] ASC_E = 8'h45;
  localparam logic [7:0] ASC_R = 8'h52;

  // Command latched on parser_done. Any data_type other than signed
  // collapses to unsigned, so only one bit is kept.
  typedef struct packed {
    logic [4:0]  op;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  // Uppercase hex: 0-9 -> 0x30.., A-F -> 0x41..
  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/hex_cal_div.sv
// hex_cal_div: 16-bit restoring divider, one quotient bit per cycle.
// The divider works on operand magnitudes. Signs are fixed up on the outputs:
//   - the quotient is negated when the operand signs differ
//   - the remainder takes the sign of the dividend
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         load operands (one cycle)
//   is_signed     treat operands as two's complement
//   dividend      16-bit dividend
//   divisor       16-bit divisor (caller guarantees non-zero)
//   done          high in the 16th active cycle; outputs are valid then
//   quotient      16-bit quotient
//   remainder     16-bit remainder
module hex_cal_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  logic        act;
  logic [3:0]  cnt;
  logic [15:0] rem_q, quo_q, dvs_q;
  logic        neg_q, neg_r;
  logic [16:0] sh;
  logic        ge;
  logic [15:0] rem_n, quo_n;

  function automatic logic [15:0] mag(input logic s, input logic [15:0] x);
    return (s && x[15]) ? -x : x;
  endfunction

  // One restoring step. The 16th step is taken combinationally in the last
  // cycle, so the caller can latch the answer at the end of that cycle.
  always_comb begin
    sh    = {rem_q, quo_q[15]};
    ge    = (sh >= {1'b0, dvs_q});
    rem_n = ge ? 16'(sh - {1'b0, dvs_q}) : sh[15:0];
    quo_n = {quo_q[14:0], ge};
  end

  assign done      = act && (cnt == 4'd15);
  assign quotient  = neg_q ? -quo_n : quo_n;
  assign remainder = neg_r ? -rem_n : rem_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      act   <= 1'b0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      act   <= 1'b1;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= mag(is_signed, dividend);
      dvs_q <= mag(is_signed, divisor);
      neg_q <= is_signed && (dividend[15] ^ divisor[15]);
      neg_r <= is_signed && dividend[15];
    end else if (act) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt   <= cnt + 4'd1;
      if (cnt == 4'd15) act <= 1'b0;
    end
  end

endmodule

// File: rtl/hex_cal_exec.sv
// hex_cal_exec: execution/response stage of the UART hex calculator.
// Operation:
//   - captures a command on parser_done
//   - computes a 32-bit result (+, -, *, and / when the divider is built)
//   - streams the result as uppercase ASCII hex, plus optional CR LF, over
//     a valid/ready link
// Illegal operators and divide-by-zero set err and emit "ERR" instead.
// Macro HEX_CAL_DIV_EN:
//   - defined: the divider is built in
//   - undefined: operator 4 is illegal
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   parser_done       one-cycle command strobe (ignored while busy)
//   operator          1 +, 2 -, 3 *, 4 /
//   data_type         2 signed, anything else unsigned
//   src1, src2        16-bit operands
//   tx_data/valid     character to UART TX
//   tx_ready          UART TX accepts character
//   busy              command in progress
//   result            last computed result
//   result_valid      one-cycle pulse on result update
//   err               error flag of the last command
module hex_cal_exec
  import hex_cal_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter bit CRLF_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        parser_done,
  input  logic [4:0]  operator,
  input  logic [3:0]  data_type,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        err
);

  localparam int         NCRLF    = CRLF_EN ? 2 : 0;
  localparam logic [3:0] LAST_HEX = 4'(NUM_DIGITS + NCRLF - 1);
  localparam logic [3:0] LAST_ERR = 4'(3 + NCRLF - 1);

  logic [1:0]  state;
  cmd_t        cmd;
  logic [3:0]  idx;
  logic [31:0] a_ext, b_ext, alu;
  logic        illegal;
  logic        last;

  always_comb begin
    a_ext = cmd.sgn ? {{16{cmd.a[15]}}, cmd.a} : {16'h0, cmd.a};
    b_ext = cmd.sgn ? {{16{cmd.b[15]}}, cmd.b} : {16'h0, cmd.b};
    case (cmd.op)
      OP_SUB:  alu = a_ext - b_ext;
      OP_MUL:  alu = a_ext * b_ext;
      default: alu = a_ext + b_ext;
    endcase
  end

  always_comb begin
    illegal = 1'b1;
    case (cmd.op)
      OP_ADD, OP_SUB, OP_MUL: illegal = 1'b0;
`ifdef HEX_CAL_DIV_EN
      OP_DIV:                 illegal = (cmd.b == 16'h0);
`endif
      default:                illegal = 1'b1;
    endcase
  end

`ifdef HEX_CAL_DIV_EN
  logic        div_done;
  logic [15:0] div_q, div_r;

  hex_cal_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (state == CALC && cmd.op == OP_DIV && !illegal),
    .is_signed (cmd.sgn),
    .dividend  (cmd.a),
    .divisor   (cmd.b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
`endif

  // Character i of the response. Hex digits run MSB nibble first over the
  // low NUM_DIGITS nibbles. CR then LF follow the digits or "ERR".
  function automatic logic [7:0] char_at(input logic [3:0] i, input logic e,
                                         input logic [31:0] r);
    logic [7:0] c;
    int         ii;
    ii = int'(i);
    c  = LF;
    if (e) begin
      if (ii == 0)      c = ASC_E;
      else if (ii < 3)  c = ASC_R;
      else if (ii == 3) c = CR;
    end else if (ii < NUM_DIGITS) begin
      c = nib2asc(4'(r >> (4 * (NUM_DIGITS - 1 - ii))));
    end else if (ii == NUM_DIGITS) begin
      c = CR;
    end
    return c;
  endfunction

  // Outputs decode straight from state. The character therefore cannot move
  // while it waits for tx_ready.
  assign tx_valid = (state == EMIT);
  assign tx_data  = tx_valid ? char_at(idx, err, result) : 8'h00;
  assign busy     = (state != IDLE);
  assign last     = (idx == (err ? LAST_ERR : LAST_HEX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd          <= '0;
      idx          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: if (parser_done) begin
          cmd   <= '{op: operator, sgn: (data_type == DT_SIGNED), a: src1, b: src2};
          err   <= 1'b0;
          idx   <= '0;
          state <= CALC;
        end
        CALC: begin
          if (illegal) begin
            err   <= 1'b1;
            state <= EMIT;
`ifdef HEX_CAL_DIV_EN
          end else if (cmd.op == OP_DIV) begin
            state <= DIV;
`endif
          end else begin
            result       <= alu;
            result_valid <= 1'b1;
            state        <= EMIT;
          end
        end
`ifdef HEX_CAL_DIV_EN
        DIV: if (div_done) begin
          result       <= {div_r, div_q};
          result_valid <= 1'b1;
          state        <= EMIT;
        end
`endif
        EMIT: if (tx_ready) begin
          if (last) state <= IDLE;
          else      idx   <= idx + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_cal_exec.sv
module tb_hex_cal_exec;

`ifdef HEX_CAL_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        parser_done = 1'b0;
  logic [4:0]  operator = '0;
  logic [3:0]  data_type = '0;
  logic [15:0] src1 = '0, src2 = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        err;

  int nc = 0, nf = 0;

  // observations of the last command
  int   obs_lat, obs_rv, obs_hold_bad;
  bit   obs_timeout;
  bq_t  obs_chars;
  // expectations of the last command
  int          exp_lat, exp_rv;
  bit          exp_err;
  logic [31:0] exp_result = '0;
  bq_t         exp_q;

  always #5 clk = ~clk;

  hex_cal_exec dut (
    .clk(clk), .rst(rst), .parser_done(parser_done), .operator(operator),
    .data_type(data_type), .src1(src1), .src2(src2), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .result(result),
    .result_valid(result_valid), .err(err)
  );

  // Reference arithmetic on wide integers straight from the operator rules.
  function automatic void model(input logic [4:0] op, input logic [3:0] dt,
                                input logic [15:0] a, input logic [15:0] b,
                                output bit e, output logic [31:0] r);
    longint sa, sb, q, m;
    sa = (dt == 4'd2) ? longint'($signed(a)) : longint'(a);
    sb = (dt == 4'd2) ? longint'($signed(b)) : longint'(b);
    e = 1'b0;
    r = '0;
    case (op)
      5'd1: r = 32'(sa + sb);
      5'd2: r = 32'(sa - sb);
      5'd3: r = 32'(sa * sb);
      5'd4: if (!DIV_ON || b == 16'h0) e = 1'b1;
            else begin q = sa / sb; m = sa % sb; r = {16'(m), 16'(q)}; end
      default: e = 1'b1;
    endcase
  endfunction

  function automatic string fmt(input bq_t q);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // Sets expectations, drives one command starting in the current cycle and
  // records what the DUT produced until busy falls. Makes no comparisons.
  task automatic do_cmd(input logic [4:0] op, input logic [3:0] dt,
                        input logic [15:0] a, input logic [15:0] b,
                        input bit stall, input bit extra_pd);
    bit e, held, stalled, fin;
    logic [31:0] r;
    logic [7:0]  held_data;
    string hx;
    int stall_cnt;
    model(op, dt, a, b, e, r);
    if (!e) exp_result = r;
    exp_err = e;
    exp_rv  = e ? 0 : 1;
    exp_lat = (!e && op == 5'd4) ? 18 : 2;
    exp_q.delete();
    hx = e ? "ERR" : $sformatf("%08h", exp_result);
    for (int i = 0; i < hx.len(); i++) begin
      logic [7:0] c;
      c = hx[i];
      if (c >= 8'h61 && c <= 8'h66) c = c - 8'h20;
      exp_q.push_back(c);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);

    parser_done = 1'b1; operator = op; data_type = dt; src1 = a; src2 = b;
    @(posedge clk); #1;
    parser_done = 1'b0;
    obs_lat = -1; obs_rv = 0; obs_hold_bad = 0; obs_timeout = 1'b0;
    obs_chars.delete();
    held = 1'b0; stalled = 1'b0; stall_cnt = 0; fin = 1'b0; held_data = '0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      parser_done = 1'b0;
      if (held && (!tx_valid || tx_data !== held_data)) obs_hold_bad++;
      if (result_valid) obs_rv++;
      if (tx_valid && obs_lat < 0) obs_lat = k;
      if (!busy && k >= 2) begin fin = 1'b1; break; end
      if (stall_cnt > 0) begin
        tx_ready = 1'b0;
        stall_cnt--;
        if (extra_pd && stall_cnt == 2) begin
          parser_done = 1'b1; operator = 5'd3; src1 = 16'hFFFF; src2 = 16'h0F0F;
        end
      end else begin
        tx_ready = 1'b1;
      end
      held = tx_valid && !tx_ready;
      held_data = tx_data;
      if (tx_valid && tx_ready) begin
        obs_chars.push_back(tx_data);
        if (stall && !stalled && obs_chars.size() == 3) begin
          stalled = 1'b1;
          stall_cnt = 5;
        end
      end
    end
    tx_ready = 1'b1;
    obs_timeout = !fin;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nc++; if (tx_valid !== 1'b0) begin nf++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    nc++; if (tx_data !== 8'h00) begin nf++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    nc++; if (busy !== 1'b0) begin nf++; $display("FAIL rst_busy got %b want 0", busy); end
    nc++; if (result !== 32'h0) begin nf++; $display("FAIL rst_result got %h want 0", result); end
    nc++; if (result_valid !== 1'b0) begin nf++; $display("FAIL rst_result_valid got %b want 0", result_valid); end
    nc++; if (err !== 1'b0) begin nf++; $display("FAIL rst_err got %b want 0", err); end
    rst = 1'b0;
    exp_result = '0;
  endtask

  task automatic test_arith();
    logic [4:0]  t_op [4] = '{5'd1, 5'd2, 5'd3, 5'd3};
    logic [3:0]  t_dt [4] = '{4'd3, 4'd2, 4'd2, 4'd3};
    logic [15:0] t_a  [4] = '{16'h0012, 16'h0003, 16'hFFFF, 16'hFFFF};
    logic [15:0] t_b  [4] = '{16'h0034, 16'h0005, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 28; i++) begin
      string nm;
      if (i < 4) do_cmd(t_op[i], t_dt[i], t_a[i], t_b[i], 1'b0, 1'b0);
      else do_cmd(5'($urandom_range(0, 6)), 4'($urandom_range(0, 4)), 16'($urandom),
                  ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
                  1'($urandom_range(0, 1)), 1'b0);
      nm = $sformatf("arith%0d", i);
      nc++; if (obs_lat != exp_lat) begin nf++; $display("FAIL %s latency got %0d want %0d", nm, obs_lat, exp_lat); end
      nc++; if (fmt(obs_chars) != fmt(exp_q)) begin nf++; $display("FAIL %s stream got %s want %s", nm, fmt(obs_chars), fmt(exp_q)); end
      nc++; if (result !== exp_result) begin nf++; $display("FAIL %s result got %h want %h", nm, result, exp_result); end
      nc++; if (obs_rv != exp_rv) begin nf++; $display("FAIL %s result_valid pulses got %0d want %0d", nm, obs_rv, exp_rv); end
      nc++; if (err !== exp_err) begin nf++; $display("FAIL %s err got %b want %b", nm, err, exp_err); end
      nc++; if (obs_hold_bad != 0 || obs_timeout) begin nf++; $display("FAIL %s handshake hold_bad %0d timeout %0d want 0 0", nm, obs_hold_bad, obs_timeout); end
    end
  endtask

  task automatic test_div();
    logic [3:0]  t_dt [3] = '{4'd3, 4'd2, 4'd2};
    logic [15:0] t_a  [3] = '{16'h0064, 16'hFF9C, 16'h8000};
    logic [15:0] t_b  [3] = '{16'h0007, 16'h0007, 16'hFFFF};
    for (int i = 0; i < 3; i++) begin
      do_cmd(5'd4, t_dt[i], t_a[i], t_b[i], 1'b0, 1'b0);
      nc++; if (obs_lat != exp_lat) begin nf++; $display("FAIL div%0d latency got %0d want %0d", i, obs_lat, exp_lat); end
      nc++; if (fmt(obs_chars) != fmt(exp_q)) begin nf++; $display("FAIL div%0d stream got %s want %s", i, fmt(obs_chars), fmt(exp_q)); end
      nc++; if (result !== exp_result) begin nf++; $display("FAIL div%0d result got %h want %h", i, result, exp_result); end
      nc++; if (err !== exp_err || obs_rv != exp_rv) begin nf++; $display("FAIL div%0d err/rv got %b/%0d want %b/%0d", i, err, obs_rv, exp_err, exp_rv); end
    end
  endtask

  task automatic test_err();
    logic [4:0] t_op [3] = '{5'd4, 5'd0, 5'd31};
    for (int i = 0; i < 3; i++) begin
      logic [31:0] prev;
      prev = result;
      do_cmd(t_op[i], 4'd3, 16'h1234, 16'h0000, 1'b0, 1'b0);
      nc++; if (err !== 1'b1) begin nf++; $display("FAIL err%0d err got %b want 1", i, err); end
      nc++; if (fmt(obs_chars) != fmt(exp_q)) begin nf++; $display("FAIL err%0d stream got %s want %s", i, fmt(obs_chars), fmt(exp_q)); end
      nc++; if (result !== prev || obs_rv != 0) begin nf++; $display("FAIL err%0d result/rv got %h/%0d want %h/0", i, result, obs_rv, prev); end
      nc++; if (obs_lat != 2) begin nf++; $display("FAIL err%0d latency got %0d want 2", i, obs_lat); end
    end
  endtask

  task automatic test_backpressure();
    do_cmd(5'd1, 4'd3, 16'h1234, 16'h0ABC, 1'b1, 1'b1);
    nc++; if (fmt(obs_chars) != fmt(exp_q)) begin nf++; $display("FAIL bp stream got %s want %s", fmt(obs_chars), fmt(exp_q)); end
    nc++; if (obs_hold_bad != 0 || obs_timeout) begin nf++; $display("FAIL bp hold_bad %0d timeout %0d want 0 0", obs_hold_bad, obs_timeout); end
    nc++; if (result !== exp_result) begin nf++; $display("FAIL bp result got %h want %h", result, exp_result); end
    @(negedge clk);
    nc++; if (busy !== 1'b0) begin nf++; $display("FAIL bp extra_pd busy got %b want 0", busy); end
  endtask

  // Each command is issued in the very cycle busy falls after the previous one.
  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      do_cmd(5'($urandom_range(1, 3)), 4'($urandom_range(2, 3)), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      nc++; if (obs_lat != 2) begin nf++; $display("FAIL b2b%0d latency got %0d want 2", i, obs_lat); end
      nc++; if (result !== exp_result || fmt(obs_chars) != fmt(exp_q)) begin nf++; $display("FAIL b2b%0d result got %h want %h", i, result, exp_result); end
    end
  endtask

  task automatic test_reset_mid();
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      parser_done = 1'b1; operator = (m == 0) ? 5'd4 : 5'd1; data_type = 4'd3;
      src1 = 16'h0064; src2 = 16'h0007; tx_ready = (m == 0);
      @(negedge clk);
      parser_done = 1'b0;
      repeat (4) @(negedge clk);
      if (m == 1) begin
        nc++; if (tx_valid !== 1'b1) begin nf++; $display("FAIL mid_emit tx_valid got %b want 1", tx_valid); end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; tx_ready = 1'b1;
      exp_result = '0;
      nc++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin nf++; $display("FAIL rst_mid%0d valid/busy got %b/%b want 0/0", m, tx_valid, busy); end
      nc++; if (result !== 32'h0 || err !== 1'b0) begin nf++; $display("FAIL rst_mid%0d result/err got %h/%b want 0/0", m, result, err); end
    end
    do_cmd(5'd3, 4'd2, 16'hFFFE, 16'h0003, 1'b0, 1'b0);
    nc++; if (result !== exp_result || fmt(obs_chars) != fmt(exp_q)) begin nf++; $display("FAIL post_rst result got %h want %h stream %s", result, exp_result, fmt(obs_chars)); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div();
    test_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule

// File: doc/hex_cal_exec.md
Name: hex_cal_exec

Overview:
Execution/response stage of the UART hex calculator, directly downstream of the command decoder. It captures src1, src2, operator and data_type when parser_done pulses, and computes a 32-bit result (add, sub, mul, iterative divide). It then streams the result as ASCII hex plus CR LF to the UART transmitter over a valid/ready handshake.

Parameters:
NUM_DIGITS, 8, hex characters emitted per result (MSB nibble first); legal values 1..8, low NUM_DIGITS nibbles of result.
CRLF_EN, 1, 1 = append 0x0D 0x0A after the digits; 0 = digits only.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
parser_done  in  1  one-cycle pulse: command complete, operands valid this cycle
operator  in  5  1 = +, 2 = -, 3 = *, 4 = /; any other value is illegal
data_type  in  4  2 = signed, 3 = unsigned; any other value is treated as unsigned
src1  in  16  first operand
src2  in  16  second operand
tx_data  out  8  ASCII character to UART TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts character
busy  out  1  high from capture until last character accepted
result  out  32  last computed result, held until next capture
result_valid  out  1  one-cycle pulse when result is updated
err  out  1  sticky error of last command; cleared on next capture

Behaviour:
- Reset (clk edge with rst = 1, also mid-operation): state IDLE; tx_valid = 0, tx_data = 0x00, busy = 0, result = 0, result_valid = 0, err = 0; any in-flight divide or string is abandoned.
- Capture: in IDLE, parser_done = 1 latches all inputs; busy = 1 from the next cycle. parser_done while busy is ignored (no queueing).
- States:
  - IDLE -> CALC on capture.
  - CALC (1 cycle) -> EMIT for +, -, *, or for an illegal operator/div-by-zero (err = 1). CALC -> DIV for / with src2 != 0.
  - DIV: 16 cycles of restoring division -> EMIT.
  - EMIT: one character per handshake -> IDLE after the last character is accepted.
- Arithmetic:
  - Unsigned: operands are zero-extended to 32 bits.
  - Signed: operands are sign-extended to 32 bits.
  - + and -: 32-bit wrap.
  - *: full 32-bit product, signed or unsigned.
  - /: result = {remainder[15:0], quotient[15:0]}. Signed divide truncates toward zero; the remainder takes the sign of the dividend. 0x8000 / 0xFFFF signed gives quotient 0x8000, remainder 0.
- Result timing: result and result_valid are updated on leaving CALC (non-divide) or DIV; the err path leaves result unchanged.
- Latency, parser_done to first tx_valid: 2 cycles for +, -, *, err; 18 cycles for /.
- EMIT characters:
  - Nibbles 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
  - Error string is fixed "ERR" (0x45 0x52 0x52) followed by CR LF if CRLF_EN.
- Handshake:
  - A character transfers when tx_valid && tx_ready on a clk edge.
  - tx_data is stable while tx_valid && !tx_ready; tx_valid never drops without a transfer.
  - The next character is presented in the cycle after a transfer.
  - tx_ready held high gives one character per cycle.
- busy deasserts in the cycle after the final transfer; a parser_done in that same cycle is accepted.

Optional Feature:
Macro HEX_CAL_DIV_EN.
- Defined: DIV state and 16-cycle divider are compiled in, as described above.
- Undefined: no divider logic; operator 4 is treated as illegal -> err = 1, "ERR" string emitted, result unchanged.

Decomposition:
- Package hex_cal_pkg holds:
  - operator codes OP_ADD = 1, OP_SUB = 2, OP_MUL = 3, OP_DIV = 4
  - data_type codes DT_SIGNED = 2, DT_UNSIGNED = 3
  - state enum IDLE/CALC/DIV/EMIT
  - ASCII constants CR, LF, and the ERR characters
  - nibble-to-ASCII function
- Sub-module hex_cal_div: 16-bit restoring divider with start/done, signed/unsigned select and sign fix-up; instantiated only under HEX_CAL_DIV_EN.

Test Plan:
1. Unsigned 0x0012 + 0x0034, tx_ready = 1 -> result 0x00000046, stream "00000046" 0x0D 0x0A, first tx_valid 2 cycles after parser_done, err = 0.
2. Signed 0x0003 - 0x0005 -> result 0xFFFFFFFE; signed 0xFFFF * 0xFFFF -> 0x00000001; unsigned 0xFFFF * 0xFFFF -> 0xFFFE0001.
3. Unsigned 0x0064 / 0x0007 -> result 0x0002000E after 18 cycles, "0002000E" streamed; signed 0xFF9C / 0x0007 -> quotient 0xFFF2, remainder 0xFFFE.
4. Divide by zero, and operator = 0 -> err = 1, stream 0x45 0x52 0x52 0x0D 0x0A, result unchanged, no result_valid pulse.
5. tx_ready low for 5 cycles after the 3rd character -> tx_data stable and tx_valid held; all 10 characters received in order; extra parser_done pulses during busy are ignored.
6. rst asserted mid-DIV and mid-EMIT -> next cycle tx_valid = 0, busy = 0, result = 0; a new command afterwards completes correctly.
